// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end (prefetch queue and fetch).
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam int          WIN_W            = 48;
  localparam int          MAX_TAKE         = 3;

  typedef logic [15:0] hw_t;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } fetch_state_e;

endpackage

// File: rtl/cpu_hw_queue.sv
// Circular halfword FIFO: 0-2 halfword write, 0-3 halfword advance, flush,
// occupancy and a 3-halfword read window (oldest in the top slice).
module cpu_hw_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       wr_n_i,
  input  hw_t              wr_hw0_i,
  input  hw_t              wr_hw1_i,
  input  logic [1:0]       rd_n_i,
  output logic [OW-1:0]    occ_o,
  output logic [WIN_W-1:0] win_o
);

  hw_t           r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [OW-1:0] r_occ;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(k);
    if (s >= (PW + 1)'(DEPTH)) s = s - (PW + 1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // NOTE: storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (wr_n_i != 2'd0) r_mem[r_wr_ptr] <= wr_hw0_i;
      if (wr_n_i == 2'd2) r_mem[ptr_add(r_wr_ptr, 2'd1)] <= wr_hw1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_wr_ptr <= ptr_add(r_wr_ptr, wr_n_i);
      r_rd_ptr <= ptr_add(r_rd_ptr, rd_n_i);
      r_occ    <= r_occ + OW'(wr_n_i) - OW'(rd_n_i);
    end
  end

  // Slots beyond occupancy read as zero so the window is clean after reset.
  always_comb begin
    win_o = '0;
    if (r_occ >= OW'(1)) win_o[47:32] = r_mem[r_rd_ptr];
    if (r_occ >= OW'(2)) win_o[31:16] = r_mem[ptr_add(r_rd_ptr, 2'd1)];
    if (r_occ >= OW'(3)) win_o[15:0]  = r_mem[ptr_add(r_rd_ptr, 2'd2)];
  end

  assign occ_o = r_occ;

endmodule

// File: rtl/cpu_prefetch.sv
// Instruction prefetch: word requests to imem, halfword queue, 3-halfword
// window for cpu_fetch, and redirect handling including odd-halfword targets.
module cpu_prefetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [WIN_W-1:0] win_o,
  output logic [1:0]       count_o,
  output logic [31:0]      pc_o,
  input  logic [1:0]       take_i
);

  localparam int OW = $clog2(DEPTH + 1);

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_pc;
  logic          r_skip_hi;
  logic          w_ack;
  logic [1:0]    w_wr_n;
  logic [1:0]    w_take;
  hw_t           w_wr_hw0;
  logic [OW-1:0] w_occ;
  logic          w_unused_pc0;

  // A redirect discards any same-cycle ack and consumption.
  assign w_ack    = (r_state == ST_REQ) && imem_ack_i && !redirect_i;
  assign w_wr_n   = w_ack ? (r_skip_hi ? 2'd1 : 2'd2) : 2'd0;
  assign w_take   = redirect_i ? 2'd0 : take_i;
  assign w_wr_hw0 = r_skip_hi ? imem_data_i[15:0] : imem_data_i[31:16];

  cpu_hw_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (redirect_i),
    .wr_n_i   (w_wr_n),
    .wr_hw0_i (w_wr_hw0),
    .wr_hw1_i (imem_data_i[15:0]),
    .rd_n_i   (w_take),
    .occ_o    (w_occ),
    .win_o    (win_o)
  );

  // NOTE: next-state is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_occ <= OW'(DEPTH - 2)) w_state_nxt = ST_REQ;
      ST_REQ:  if (imem_ack_i)              w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
    if (redirect_i) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_skip_hi    <= RESET_PC[1];
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i) begin
        r_pc         <= {redirect_pc_i[31:1], 1'b0};
        r_fetch_addr <= {redirect_pc_i[31:2], 2'b00};
        r_skip_hi    <= redirect_pc_i[1];
      end else begin
        r_pc <= r_pc + {29'd0, w_take, 1'b0};
        if (w_ack) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
          r_skip_hi    <= 1'b0;
        end
      end
    end
  end

  assign imem_req_o   = (r_state == ST_REQ);
  assign imem_addr_o  = r_fetch_addr;
  assign pc_o         = r_pc;
  assign count_o      = (w_occ >= OW'(MAX_TAKE)) ? 2'd3 : w_occ[1:0];
  assign w_unused_pc0 = redirect_pc_i[0];

endmodule

// File: tb/tb_cpu_prefetch.sv
// Self-checking bench for cpu_prefetch: directed scenarios plus a randomized
// run checked against the sequential halfword stream of a memory image.
module tb_cpu_prefetch;
  import cpu_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef enum int { M_ZERO, M_RAND, M_OFF } mem_mode_e;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic             imem_ack_i;
  logic [31:0]      imem_data_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic [WIN_W-1:0] win_o;
  logic [1:0]       count_o;
  logic [31:0]      pc_o;
  logic [1:0]       take_i;

  int          total = 0;
  int          bad   = 0;
  mem_mode_e   mode;
  logic        force_en;
  logic [31:0] force_word;
  bit          busy;
  int          wait_left;
  int          ack_cnt;

  cpu_prefetch #(.RESET_PC(RPC), .DEPTH(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .win_o         (win_o),
    .count_o       (count_o),
    .pc_o          (pc_o),
    .take_i        (take_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h1234_5678;
    if (a == 32'h0000_2000) return 32'hAAAA_BBBB;
    return {a[15:0] ^ a[31:16] ^ 16'h5A3C, a[17:2] + 16'h1357};
  endfunction

  function automatic hw_t hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_fn({a[31:2], 2'b00});
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  // Memory responder, evaluated once per cycle at the falling edge.
  task automatic drive_mem();
    imem_ack_i  = 1'b0;
    imem_data_i = 32'h0;
    if (!imem_req_o || mode == M_OFF) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy      = 1'b1;
        wait_left = (mode == M_RAND) ? int'($urandom_range(0, 4)) : 0;
      end
      if (wait_left == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = force_en ? force_word : mem_fn(imem_addr_o);
        busy        = 1'b0;
        ack_cnt++;
      end else begin
        wait_left--;
      end
    end
  endtask

  task automatic cycle(input logic [1:0] take, input logic redir, input logic [31:0] rpc);
    drive_mem();
    take_i        = take;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle(2'd0, 1'b0, 32'h0);
    cycle(2'd0, 1'b0, 32'h0);
    rst_i = 1'b0;
    busy  = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!imem_req_o && n < budget) begin
      cycle(2'd0, 1'b0, 32'h0);
      n++;
    end
    check(tag, 48'(imem_req_o), 48'd1);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    int          t;
    int          n;

    rst_i = 1'b1; imem_ack_i = 1'b0; imem_data_i = '0; redirect_i = 1'b0;
    redirect_pc_i = '0; take_i = '0; mode = M_ZERO; force_en = 1'b0;
    force_word = '0; busy = 1'b0; wait_left = 0; ack_cnt = 0;

    // Reset state and first transaction
    do_reset();
    check("rst_req",   48'(imem_req_o), 48'd0);
    check("rst_addr",  48'(imem_addr_o), 48'h1000);
    check("rst_count", 48'(count_o), 48'd0);
    check("rst_pc",    48'(pc_o), 48'h1000);
    check("rst_win",   win_o, 48'd0);
    ack_cnt = 0;
    wait_req("first_req", 5);
    check("first_addr", 48'(imem_addr_o), 48'h1000);
    cycle(2'd0, 1'b0, 32'h0);
    check("ack1_count", 48'(count_o), 48'd2);
    check("ack1_win",   48'(win_o[47:16]), 48'h1234_5678);
    check("ack1_pc",    48'(pc_o), 48'h1000);

    // Fill without taking: four acks then quiet
    repeat (20) cycle(2'd0, 1'b0, 32'h0);
    check("fill_acks",  48'(ack_cnt), 48'd4);
    check("fill_req",   48'(imem_req_o), 48'd0);
    check("fill_count", 48'(count_o), 48'd3);
    ack_cnt = 0;
    cycle(2'd3, 1'b0, 32'h0);
    repeat (10) cycle(2'd0, 1'b0, 32'h0);
    check("refill_acks", 48'(ack_cnt), 48'd1);
    check("refill_pc",   48'(pc_o), 48'h1006);
    check("refill_win",  win_o, {hw_at(32'h1006), hw_at(32'h1008), hw_at(32'h100A)});

    // Reset while a request is outstanding at occupancy 5
    mode = M_OFF;
    cycle(2'd2, 1'b0, 32'h0);
    wait_req("occ5_req", 5);
    rst_i = 1'b1;
    cycle(2'd0, 1'b0, 32'h0);
    check("midrst_count", 48'(count_o), 48'd0);
    check("midrst_req",   48'(imem_req_o), 48'd0);
    check("midrst_pc",    48'(pc_o), 48'(RPC));
    check("midrst_addr",  48'(imem_addr_o), 48'(RPC));
    rst_i = 1'b0;

    // Redirect to an odd-halfword target
    mode = M_ZERO;
    do_reset();
    repeat (4) cycle(2'd0, 1'b0, 32'h0);
    cycle(2'd0, 1'b1, 32'h2002);
    check("redir_pc",    48'(pc_o), 48'h2002);
    check("redir_count", 48'(count_o), 48'd0);
    wait_req("redir_req", 5);
    check("redir_addr", 48'(imem_addr_o), 48'h2000);
    cycle(2'd0, 1'b0, 32'h0);
    check("redir_ack_count", 48'(count_o), 48'd1);
    check("redir_ack_win",   48'(win_o[47:32]), 48'hBBBB);
    check("redir_ack_pc",    48'(pc_o), 48'h2002);
    wait_req("redir_req2", 5);
    check("redir_addr2", 48'(imem_addr_o), 48'h2004);

    // Redirect coinciding with an ack: that data is dropped
    do_reset();
    wait_req("db_req", 5);
    force_en   = 1'b1;
    force_word = 32'hDEAD_BEEF;
    cycle(2'd0, 1'b1, 32'h3000);
    force_en = 1'b0;
    check("db_count", 48'(count_o), 48'd0);
    n = 0;
    while (count_o == 2'd0 && n < 10) begin
      cycle(2'd0, 1'b0, 32'h0);
      n++;
    end
    check("db_win", 48'(win_o[47:32]), 48'(hw_at(32'h3000)));
    check("db_pc",  48'(pc_o), 48'h3000);

    // Random latency, random legal takes, occasional redirects (some near wrap)
    mode = M_RAND;
    do_reset();
    exp_pc = RPC;
    for (int c = 0; c < 1500; c++) begin
      check("rnd_pc", 48'(pc_o), 48'(exp_pc));
      if ($urandom_range(0, 99) < 2) begin
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | ($urandom() & 32'h6)) : $urandom();
        cycle(2'd0, 1'b1, rpc);
        exp_pc = {rpc[31:1], 1'b0};
      end else begin
        t = int'($urandom_range(0, int'(count_o)));
        for (int i = 0; i < t; i++)
          check("rnd_hw", 48'(win_o[47-16*i -: 16]), 48'(hw_at(exp_pc + 32'(2 * i))));
        cycle(2'(t), 1'b0, 32'h0);
        exp_pc = exp_pc + 32'(2 * t);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
